// File: rtl/lpf_pkg.sv
// ============================================================================
//  Module      : lpf_pkg
//  Description : Shared definitions for the motor low-pass filter bank.
//                Holds the default channel count, sample width and filter
//                shift, plus a helper that gives the bit offset of a channel
//                inside a flattened multi-channel bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lpf_pkg;

    localparam int NUM_MOTOR_CH = 5;   // one filter channel per motor
    localparam int FILT_WIDTH   = 16;  // signed sample / result width
    localparam int FILT_GAIN    = 4;   // alpha = 2^-FILT_GAIN

    // LSB position of channel 'ch' in a bus of 'width'-bit lanes.
    function automatic int ch_slice(input int ch, input int width);
        return ch * width;
    endfunction

endpackage : lpf_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Starting at the
//                priority pointer, the first asserted request (searching
//                ptr, ptr+1, ... modulo N) receives a one-hot grant.
//  Ports       : i_req       [N-1:0]      request vector
//                i_ptr       [IDX_W-1:0]  highest-priority index (0..N-1)
//                o_grant     [N-1:0]      one-hot grant, all zero if idle
//                o_grant_idx [IDX_W-1:0]  binary index of the granted req
//                o_any                    at least one request granted
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_sum       = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index = (ptr + i) mod N; both terms are < N so a
            // single conditional subtract is enough.
            w_sum = {1'b0, i_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(N)) begin
                w_sum = w_sum - SUM_W'(N);
            end
            if (!o_any && i_req[w_sum[IDX_W-1:0]]) begin
                o_any                        = 1'b1;
                o_grant[w_sum[IDX_W-1:0]]    = 1'b1;
                o_grant_idx                  = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/iir_lpf_scheduler.sv
// ============================================================================
//  Module      : iir_lpf_scheduler
//  Description : Time-multiplexed first-order IIR low-pass filter bank.
//                One shared add/subtract datapath serves NUM_CH channels;
//                a round-robin arbiter picks one requesting channel per
//                cycle. Per channel: acc += x - (acc >>> GAIN), result is
//                acc >>> GAIN. All filtered values are also exported
//                continuously on filt_all.
//  Ports       : clk, reset            clock, synchronous active-high reset
//                en                    global enable (0 = no grants, hold)
//                in_valid  [NUM_CH]    per-channel sample request
//                in_data   [NUM_CH*W]  samples, ch k at [k*W +: W]
//                in_ready  [NUM_CH]    one-hot grant (combinational)
//                clear     [NUM_CH]    per-channel accumulator zero request
//                out_valid             one result this cycle
//                out_ch                channel of the result
//                out_data  [W]         filtered result
//                filt_all  [NUM_CH*W]  filtered value of every channel
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module iir_lpf_scheduler
    import lpf_pkg::*;
#(
    parameter int NUM_CH = NUM_MOTOR_CH,
    parameter int WIDTH  = FILT_WIDTH,
    parameter int GAIN   = FILT_GAIN,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH-1:0]       clear,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic [WIDTH-1:0]        out_data,
    output logic [NUM_CH*WIDTH-1:0] filt_all
);

    localparam int ACC_W = WIDTH + GAIN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_acc [NUM_CH];
    logic [CH_W-1:0]         r_ptr;
    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic [WIDTH-1:0]        r_out_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_gidx;
    logic              w_any;

    // A channel being cleared is withheld so clear and update never collide.
    assign w_elig = {NUM_CH{en}} & in_valid & ~clear;

    rr_arbiter #(
        .N     (NUM_CH),
        .IDX_W (CH_W)
    ) u_arb (
        .i_req       (w_elig),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    assign in_ready = w_grant;

    // ------------------------------------------------------------------
    // Shared datapath: select granted sample and accumulator, one update
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] w_sample;
    logic signed [ACC_W-1:0] w_acc_cur;
    logic signed [ACC_W-1:0] w_sample_ext;
    logic signed [ACC_W-1:0] w_filt_ext;
    logic signed [ACC_W-1:0] w_acc_nxt;

    always_comb begin
        w_sample  = '0;
        w_acc_cur = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_gidx == CH_W'(k)) begin
                w_sample  = in_data[ch_slice(k, WIDTH) +: WIDTH];
                w_acc_cur = r_acc[k];
            end
        end
        w_sample_ext = {{GAIN{w_sample[WIDTH-1]}}, w_sample};
        // Upper WIDTH bits of acc, sign-extended: an arithmetic shift, so
        // negative values round toward -inf.
        w_filt_ext   = {{GAIN{w_acc_cur[ACC_W-1]}}, w_acc_cur[ACC_W-1:GAIN]};
        // Two's-complement wrap; steady state stays within input range.
        w_acc_nxt    = w_acc_cur + w_sample_ext - w_filt_ext;
    end

    // ------------------------------------------------------------------
    // Accumulator array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (reset || clear[k]) begin
                r_acc[k] <= '0;
            end else if (w_any && (w_gidx == CH_W'(k))) begin
                r_acc[k] <= w_acc_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: moves past the winner only on a transfer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + CH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output register: one-cycle pulse, channel/data hold between results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_ch   <= w_gidx;
                r_out_data <= w_acc_nxt[ACC_W-1:GAIN];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Continuous readback of every channel's filtered value
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_filt
            assign filt_all[k*WIDTH +: WIDTH] = r_acc[k][ACC_W-1:GAIN];
        end
    endgenerate

endmodule : iir_lpf_scheduler

`default_nettype wire

// File: tb/tb_iir_lpf_scheduler.sv
// ============================================================================
//  Module      : tb_iir_lpf_scheduler
//  Description : Scoreboard bench for iir_lpf_scheduler (5 ch, 16 bit,
//                gain 4). Stimulus pushes the expected next-cycle outputs
//                into a queue; a monitor on the falling edge pops and
//                compares them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iir_lpf_scheduler;

    localparam int NC = 5;
    localparam int W  = 16;
    localparam int G  = 4;
    localparam int AW = W + G;

    logic            clk;
    logic            reset;
    logic            en;
    logic [NC-1:0]   in_valid;
    logic [NC*W-1:0] in_data;
    logic [NC-1:0]   in_ready;
    logic [NC-1:0]   clear;
    logic            out_valid;
    logic [2:0]      out_ch;
    logic [W-1:0]    out_data;
    logic [NC*W-1:0] filt_all;

    iir_lpf_scheduler #(.NUM_CH(NC), .WIDTH(W), .GAIN(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .filt_all  (filt_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic            vld;
        logic [2:0]      ch;
        logic [W-1:0]    data;
        logic [NC*W-1:0] filt;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [NC*W-1:0] got, input logic [NC*W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    // Reference filter state
    logic signed [AW-1:0] m_acc [NC];
    int                   m_ptr = 0;
    logic [2:0]           m_och = '0;
    logic [W-1:0]         m_od  = '0;

    initial for (int k = 0; k < NC; k++) m_acc[k] = '0;

    // Apply current inputs for one cycle: check grant, predict outputs.
    task automatic step();
        logic [NC-1:0]        elig;
        logic [NC-1:0]        g;
        int                   gi;
        int                   c;
        exp_t                 e;
        logic signed [W-1:0]  s;
        logic signed [AW-1:0] nx;
        #1;
        elig = {NC{en}} & in_valid & ~clear;
        g    = '0;
        gi   = -1;
        for (int i = 0; i < NC; i++) begin
            c = (m_ptr + i) % NC;
            if (gi < 0 && elig[c]) begin
                gi   = c;
                g[c] = 1'b1;
            end
        end
        if (!reset) chk("in_ready", NC*W'(in_ready), NC*W'(g));
        e.cyc = cyc + 1;
        e.vld = 1'b0;
        if (reset) begin
            for (int k = 0; k < NC; k++) m_acc[k] = '0;
            m_ptr = 0;
            m_och = '0;
            m_od  = '0;
        end else begin
            for (int k = 0; k < NC; k++) if (clear[k]) m_acc[k] = '0;
            if (gi >= 0) begin
                s         = in_data[gi*W +: W];
                nx        = m_acc[gi] + AW'(s) - (m_acc[gi] >>> G);
                m_acc[gi] = nx;
                m_ptr     = (gi + 1) % NC;
                m_och     = 3'(gi);
                m_od      = nx[AW-1:G];
                e.vld     = 1'b1;
            end
        end
        e.ch   = m_och;
        e.data = m_od;
        for (int k = 0; k < NC; k++) e.filt[k*W +: W] = m_acc[k][AW-1:G];
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs with the entry due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("out_valid", NC*W'(out_valid), NC*W'(e.vld));
                chk("out_ch",    NC*W'(out_ch),    NC*W'(e.ch));
                chk("out_data",  NC*W'(out_data),  NC*W'(e.data));
                chk("filt_all",  filt_all,         e.filt);
            end
        end
    end

    initial begin
        logic [W-1:0] t1 [3];
        logic [W-1:0] t3 [3];
        // Hand-derived: acc 160 -> 310 -> 451 ; -160 -> -310 -> -450
        t1[0] = 16'd10;  t1[1] = 16'd19;  t1[2] = 16'd28;
        t3[0] = 16'hFFF6; t3[1] = 16'hFFEC; t3[2] = 16'hFFE3;

        reset    = 1'b1;
        en       = 1'b1;
        in_valid = '0;
        in_data  = '0;
        clear    = '0;
        step();
        step();

        // 1: ch0 held valid with 160
        reset         = 1'b0;
        in_valid      = 5'b00001;
        in_data[0+:W] = 16'd160;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_out_data", NC*W'(out_data), NC*W'(t1[i]));
        end
        in_valid = '0;
        step();

        // 2: all channels valid, rotating grants
        in_data  = {16'h8000, 16'h7FFF, 16'd300, 16'hF830, 16'd1000};
        in_valid = 5'b11111;
        repeat (10) step();

        // 3: clear everything, then ch2 with -160
        in_valid = '0;
        clear    = 5'b11111;
        step();
        clear           = '0;
        in_data[2*W+:W] = 16'hFF60;
        in_valid        = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_out_data", NC*W'(out_data), NC*W'(t3[i]));
            chk("t3_filt2",    NC*W'(filt_all[2*W +: W]), NC*W'(t3[i]));
        end
        in_valid = '0;
        step();

        // 4: ch1 builds up, then clear[1] while ch1 and ch3 request
        in_data[1*W+:W] = 16'd500;
        in_data[3*W+:W] = 16'hFD44;
        in_valid        = 5'b00010;
        repeat (2) step();
        in_valid = 5'b01010;
        clear    = 5'b00010;
        step();
        chk("t4_filt1_zero", NC*W'(filt_all[1*W +: W]), '0);
        clear    = '0;
        in_valid = '0;
        step();

        // 5: enable dropped with requests pending; clear still works
        in_valid = 5'b11111;
        repeat (2) step();
        en = 1'b0;
        step();
        clear = 5'b00001;
        step();
        clear = '0;
        repeat (2) step();
        en = 1'b1;
        repeat (5) step();

        // 6: reset mid-stream, first grant goes to lowest valid channel
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("t6_filt_zero", filt_all, '0);
        reset    = 1'b0;
        in_valid = 5'b11000;
        #1;
        chk("t6_first_grant", NC*W'(in_ready), NC*W'(5'b01000));
        repeat (3) step();
        in_valid = '0;
        repeat (2) step();

        @(negedge clk);
        #1;
        chk("queue_drain", NC*W'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_iir_lpf_scheduler

`default_nettype wire
